// File: rtl/video_pkg.sv
// Shared video stream types: capture FSM states, word-FIFO entry layout
// and the RGB888 -> RGB565 conversion.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [15:0] rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/video_capture_565_if.sv
// Word stream from the capture block to a frame-buffer writer (valid/ready).
interface video_capture_565_if;
  import video_pkg::*;

  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        sof;
  logic        eol;

  modport master (output valid, output data, output sof, output eol, input ready);
  modport slave  (input valid, input data, input sof, input eol, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and show-ahead read port;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_rd;
  logic             w_wr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/video_capture_565.sv
// RGB888 hs/vs/de sink: converts to RGB565, packs pixel pairs into 32-bit
// words for a frame-buffer writer, measures active size, flags dropped frames.
module video_capture_565
  import video_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_hs,
  input  logic                 in_vs,
  input  logic                 in_de,
  input  logic [23:0]          in_data,
  video_capture_565_if.master  out,
  output logic [CNT_W-1:0]     frame_width,
  output logic [CNT_W-1:0]     frame_height,
  output logic                 overflow
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic        r_vs, r_vs_d, r_de, r_de_d;
  logic [23:0] r_rgb;
  logic        w_vs_rise, w_de_fall;
  logic [15:0] w_pix;
  logic        w_unused;

  state_t      r_state;

  logic        r_have0;
  logic [15:0] r_pix0;
  logic        r_word_vld;
  logic [31:0] r_word;
  logic        r_word_sof;
  logic        r_word_eol;
  logic        r_sof_pend;

  logic [CNT_W-1:0] r_pix_cnt, r_line_w, r_line_cnt;
  logic [CNT_W-1:0] w_line_w_nxt, w_lines_nxt;

  logic              w_push, w_push_fail, w_full, w_empty;
  fifo_entry_t       w_push_entry, w_head;
  logic [ENTRY_W-1:0] w_fifo_din, w_fifo_dout;

  assign w_unused  = ^{in_hs, r_rgb[18:16], r_rgb[9:8], r_rgb[2:0]};
  assign w_vs_rise = r_vs && !r_vs_d;
  assign w_de_fall = r_de_d && !r_de;
  assign w_pix     = rgb565(r_rgb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_de   <= 1'b0;
      r_de_d <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_vs   <= in_vs;
      r_vs_d <= r_vs;
      r_de   <= in_de;
      r_de_d <= r_de;
      r_rgb  <= in_data;
    end
  end

  // Packer: a pair word is staged here and pushed one cycle later, so the
  // push cycle already knows whether de fell right after the odd pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_have0    <= 1'b0;
      r_pix0     <= '0;
      r_word_vld <= 1'b0;
      r_word     <= '0;
      r_word_sof <= 1'b0;
      r_word_eol <= 1'b0;
      r_sof_pend <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (r_state == CAPTURE) begin
        if (w_de_fall && r_have0) begin
          r_word     <= {16'h0000, r_pix0};
          r_word_vld <= 1'b1;
          r_word_sof <= r_sof_pend;
          r_word_eol <= 1'b1;
          r_sof_pend <= 1'b0;
        end else if (r_de && !w_vs_rise) begin
          if (r_have0) begin
            r_word     <= {w_pix, r_pix0};
            r_word_vld <= 1'b1;
            r_word_sof <= r_sof_pend;
            r_word_eol <= 1'b0;
            r_sof_pend <= 1'b0;
            r_have0    <= 1'b0;
          end else begin
            r_pix0  <= w_pix;
            r_have0 <= 1'b1;
          end
        end
      end else begin
        r_have0 <= 1'b0;
      end
      if (w_de_fall) r_have0 <= 1'b0;
      if (w_vs_rise) begin
        r_have0    <= 1'b0;
        r_sof_pend <= 1'b1;
      end
    end
  end

  assign w_push       = r_word_vld && (r_state == CAPTURE);
  assign w_push_fail  = w_push && w_full && !out.ready;
  assign w_push_entry = '{sof: r_word_sof, eol: r_word_eol | w_de_fall, data: r_word};
  assign w_fifo_din   = w_push_entry;

  // A frame boundary outranks a failed push of the frame that is ending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_vs_rise) r_state <= CAPTURE;
        CAPTURE: begin
          if (w_vs_rise) begin
            r_state <= CAPTURE;
          end else if (w_push_fail) begin
            r_state  <= DROP;
            overflow <= 1'b1;
          end
        end
        DROP: begin
          if (w_vs_rise) begin
            r_state  <= CAPTURE;
            overflow <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_line_w_nxt = w_de_fall ? r_pix_cnt : r_line_w;
  assign w_lines_nxt  = w_de_fall ? sat_inc(r_line_cnt) : r_line_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt    <= '0;
      r_line_w     <= '0;
      r_line_cnt   <= '0;
      frame_width  <= '0;
      frame_height <= '0;
    end else begin
      if (r_de) r_pix_cnt <= sat_inc(r_pix_cnt);
      if (w_de_fall) begin
        r_line_w  <= r_pix_cnt;
        r_pix_cnt <= '0;
      end
      if (w_vs_rise) begin
        r_line_cnt <= '0;
        if (r_state != IDLE) begin
          frame_width  <= w_line_w_nxt;
          frame_height <= w_lines_nxt;
        end
      end else begin
        r_line_cnt <= w_lines_nxt;
      end
    end
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_fifo_din),
    .i_pop  (out.ready),
    .o_data (w_fifo_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_head    = w_fifo_dout;
  assign out.valid = !w_empty;
  assign out.data  = w_empty ? '0 : w_head.data;
  assign out.sof   = !w_empty && w_head.sof;
  assign out.eol   = !w_empty && w_head.eol;

endmodule
